e_stop_debounce: RTL



---
 rtl/e_stop_pkg.sv | 6 +
 rtl/e_stop_sync.sv | 14 +
 rtl/e_stop_debounce.sv | 92 +++++++++
 3 files changed

// File: rtl/e_stop_pkg.sv
// e_stop_pkg: shared state encoding and glitch counter limits for the e-stop conditioner
package e_stop_pkg;
  typedef enum logic [2:0] {RELEASED, PRESS_PEND, ACTIVE, RELEASE_PEND, HELD} state_t;
  localparam int GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;
endpackage

// File: rtl/e_stop_sync.sv
// e_stop_sync: 2-FF synchroniser; ports clk, reset_n (sync, active-low), d (async in), q (synced out, RESET_VAL in reset)
module e_stop_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (!reset_n) {q, meta} <= {2{RESET_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/e_stop_debounce.sv
// e_stop_debounce: synchronise, debounce and optionally latch (E_STOP_LATCH_EN) the e-stop pin
//   ports: clk, reset_n (sync, active-low), e_stop_raw (async pin), clear (1-cycle sw clear),
//          e_stop_out (1 = stop, asserted out of reset), e_stop_edge (0->1 pulse), glitch_count (saturating)
module e_stop_debounce
  import e_stop_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int ACTIVE_LOW_IN   = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                e_stop_raw,
  input  logic                clear,
  output logic                e_stop_out,
  output logic                e_stop_edge,
  output logic [GLITCH_W-1:0] glitch_count
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic synced, p, p_eff, glitch, out_nx;
  logic [1:0] primed;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [GLITCH_W-1:0] glitch_nx;
  state_t state, state_nx;
  e_stop_sync #(.RESET_VAL(ACTIVE_LOW_IN != 0)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (e_stop_raw),
    .q       (synced)
  );
  assign p = (ACTIVE_LOW_IN != 0) ? ~synced : synced;
  // the synchroniser's reset contents are not real pin samples, so treat the pin
  // as pressed until both flops have captured it; a release then needs 2+N samples
  assign p_eff = p | ~primed[1];
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    glitch   = 1'b0;
    case (state)
      RELEASED:
        if (p_eff) begin
          state_nx = PRESS_PEND;
          cnt_nx   = CNT_W'(1);
        end
      PRESS_PEND:
        if (!p_eff) begin
          state_nx = RELEASED;
          glitch   = 1'b1;
        end else if (cnt == CNT_LAST) state_nx = ACTIVE;
        else cnt_nx = cnt + 1'b1;
      ACTIVE:
        if (!p_eff) begin
          state_nx = RELEASE_PEND;
          cnt_nx   = CNT_W'(1);
        end
      RELEASE_PEND:
        if (p_eff) begin
          state_nx = ACTIVE;
          glitch   = 1'b1;
        end else if (cnt == CNT_LAST) begin
`ifdef E_STOP_LATCH_EN
          state_nx = HELD;
`else
          state_nx = RELEASED;
`endif
        end else cnt_nx = cnt + 1'b1;
`ifdef E_STOP_LATCH_EN
      HELD:
        if (clear && !p_eff) state_nx = RELEASED;
`endif
      default: state_nx = ACTIVE;
    endcase
    out_nx    = state_nx inside {ACTIVE, RELEASE_PEND, HELD};
    glitch_nx = clear ? '0 : (glitch && glitch_count != GLITCH_MAX) ? glitch_count + 1'b1 : glitch_count;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state        <= ACTIVE;
      cnt          <= '0;
      primed       <= '0;
      e_stop_out   <= 1'b1;
      e_stop_edge  <= 1'b0;
      glitch_count <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      primed       <= {primed[0], 1'b1};
      e_stop_out   <= out_nx;
      e_stop_edge  <= out_nx & ~e_stop_out;
      glitch_count <= glitch_nx;
    end
endmodule
